// File: rtl/jk_mod_counter_pkg.sv
// Shared constants for the JK-based modulo counter: direction encoding and
// the terminal-value helper.
package jk_mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Highest legal count for a given modulo.
  function automatic int unsigned max_count(input int unsigned modulo);
    return modulo - 1;
  endfunction

endpackage

// File: rtl/jk_cell_ar.sv
// Single-bit JK storage cell with asynchronous active-high reset to 0.
module jk_cell_ar (
  input  logic clk,
  input  logic rst,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_o <= 1'b0;
    end else begin
      unique case ({j_i, k_i})
        2'b00:   q_o <= q_o;
        2'b10:   q_o <= 1'b1;
        2'b01:   q_o <= 1'b0;
        default: q_o <= ~q_o;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter: computes the next state and drives it into a bank
// of JK cells as toggle-only excitation, plus terminal-count/load-error flags.
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MODULO = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc,
  output logic             load_err
);

  if (MODULO < 2 || 64'(MODULO) > (64'(1) << WIDTH)) begin : g_bad_modulo
    $error("jk_mod_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(max_count(MODULO));

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] toggle;

  always_comb begin
    nxt      = count;
    load_err = 1'b0;
    if (load) begin
      // load_val >= MODULO is the same test as load_val > MaxVal at WIDTH bits
      if (load_val > MaxVal) begin
        nxt      = '0;
        load_err = 1'b1;
      end else begin
        nxt = load_val;
      end
    end else if (en) begin
      if (up == DIR_UP) begin
        nxt = (count == MaxVal) ? '0 : count + 1'b1;
      end else begin
        nxt = (count == '0) ? MaxVal : count - 1'b1;
      end
    end
  end

  // Only hold (00) and toggle (11) are ever issued to the cells.
  assign toggle = count ^ nxt;
  assign j_vec  = toggle;
  assign k_vec  = toggle;

  assign tc = en & ~load & (((up == DIR_UP) & (count == MaxVal)) |
                            ((up == DIR_DOWN) & (count == '0)));

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell_ar u_cell (
      .clk (clk),
      .rst (rst),
      .j_i (j_vec[i]),
      .k_i (k_vec[i]),
      .q_o (count[i])
    );
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter (WIDTH=4, MODULO=10) using a
// queue-based scoreboard of expected next counts.
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, load;
  logic [3:0] load_val;
  logic [3:0] count, j_vec, k_vec;
  logic       tc, load_err;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] exp_q[$];
  logic [3:0] model_cnt;
  logic [3:0] exp_t;
  logic       exp_tc, exp_err;
  logic [3:0] exp_c;

  jk_mod_counter #(.WIDTH(4), .MODULO(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .j_vec    (j_vec),
    .k_vec    (k_vec),
    .tc       (tc),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] model_next(input logic [3:0] c, input logic e, input logic u,
                                            input logic l, input logic [3:0] v);
    if (l) return (v < 4'd10) ? v : 4'd0;
    if (e && u) return (c == 4'd9) ? 4'd0 : c + 4'd1;
    if (e && !u) return (c == 4'd0) ? 4'd9 : c - 4'd1;
    return c;
  endfunction

  // Drive inputs after the falling edge and record what the DUT must do.
  task automatic apply(input logic e, input logic u, input logic l, input logic [3:0] v);
    logic [3:0] n;
    @(negedge clk);
    en = e; up = u; load = l; load_val = v;
    #1;
    n       = model_next(model_cnt, e, u, l, v);
    exp_t   = model_cnt ^ n;
    exp_tc  = e & ~l & ((u & (model_cnt == 4'd9)) | (~u & (model_cnt == 4'd0)));
    exp_err = l & (v >= 4'd10);
    exp_q.push_back(n);
    model_cnt = n;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 4'd0;
    model_cnt = 4'd0;
    #3;
    n_vec++;
    if (count !== 4'd0 || j_vec !== 4'd0 || k_vec !== 4'd0 || tc !== 1'b0 || load_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: count=%h j=%h k=%h tc=%b err=%b, want all 0",
               count, j_vec, k_vec, tc, load_err);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      apply(1'b1, 1'b1, 1'b0, 4'd0);
      tick();
      exp_c = exp_q.pop_front();
      n_vec++;
      if (count !== exp_c) begin
        n_err++;
        $display("FAIL reset_preload_count: got %h want %h", count, exp_c);
      end
    end
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (count !== 4'd0 || j_vec !== 4'd0 || k_vec !== 4'd0) begin
      n_err++;
      $display("FAIL async_reset: count=%h j=%h k=%h, want 0 0 0", count, j_vec, k_vec);
    end
    #1 rst = 1'b0;
    model_cnt = 4'd0;
    exp_q.delete();
    tick();
    n_vec++;
    if (count !== 4'd0) begin
      n_err++;
      $display("FAIL post_reset_hold: got %h want 0", count);
    end
  endtask

  task automatic test_up_wrap;
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 1'b1, 1'b0, 4'd0);
      n_vec++;
      if (tc !== exp_tc || j_vec !== exp_t || k_vec !== exp_t) begin
        n_err++;
        $display("FAIL up_comb: tc=%b j=%h k=%h, want tc=%b j=k=%h", tc, j_vec, k_vec, exp_tc,
                 exp_t);
      end
      if (count == 4'd7) begin
        n_vec++;
        if (j_vec !== 4'b1111 || k_vec !== 4'b1111) begin
          n_err++;
          $display("FAIL up_7to8_excite: j=%b k=%b want 1111", j_vec, k_vec);
        end
      end
      tick();
      exp_c = exp_q.pop_front();
      n_vec++;
      if (count !== exp_c) begin
        n_err++;
        $display("FAIL up_count: got %h want %h", count, exp_c);
      end
    end
  endtask

  task automatic test_down_wrap;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 1'b0, 4'd0);
      n_vec++;
      if (tc !== exp_tc || j_vec !== exp_t) begin
        n_err++;
        $display("FAIL down_comb: tc=%b j=%h want tc=%b j=%h", tc, j_vec, exp_tc, exp_t);
      end
      tick();
      exp_c = exp_q.pop_front();
      n_vec++;
      if (count !== exp_c) begin
        n_err++;
        $display("FAIL down_count: got %h want %h", count, exp_c);
      end
    end
    n_vec++;
    if (count !== 4'd7) begin
      n_err++;
      $display("FAIL down_end: got %h want 7", count);
    end
  endtask

  task automatic test_load_priority;
    apply(1'b0, 1'b0, 1'b1, 4'd3);
    tick();
    exp_c = exp_q.pop_front();
    apply(1'b1, 1'b1, 1'b1, 4'd6);
    n_vec++;
    if (tc !== 1'b0 || load_err !== 1'b0 || tc !== exp_tc || load_err !== exp_err) begin
      n_err++;
      $display("FAIL load_flags: tc=%b err=%b want 0 0", tc, load_err);
    end
    tick();
    exp_c = exp_q.pop_front();
    n_vec++;
    if (count !== exp_c) begin
      n_err++;
      $display("FAIL load_priority: got %h want %h", count, exp_c);
    end
  endtask

  task automatic test_illegal_load;
    apply(1'b1, 1'b0, 1'b1, 4'd12);
    n_vec++;
    if (load_err !== exp_err || tc !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_flag: err=%b tc=%b want err=%b tc=0", load_err, tc, exp_err);
    end
    tick();
    exp_c = exp_q.pop_front();
    n_vec++;
    if (count !== exp_c) begin
      n_err++;
      $display("FAIL illegal_next: got %h want %h", count, exp_c);
    end
  endtask

  task automatic test_hold_flip;
    apply(1'b0, 1'b0, 1'b1, 4'd5);
    tick();
    exp_c = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, i[0], 1'b0, 4'd0);
      n_vec++;
      if (j_vec !== 4'd0 || k_vec !== 4'd0 || tc !== 1'b0) begin
        n_err++;
        $display("FAIL hold_excite: j=%h k=%h tc=%b want 0 0 0", j_vec, k_vec, tc);
      end
      tick();
      exp_c = exp_q.pop_front();
      n_vec++;
      if (count !== exp_c) begin
        n_err++;
        $display("FAIL hold_count: got %h want %h", count, exp_c);
      end
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, ~i[0], 1'b0, 4'd0);
      tick();
      exp_c = exp_q.pop_front();
      n_vec++;
      if (count !== exp_c) begin
        n_err++;
        $display("FAIL flip_count: step %0d got %h want %h", i, count, exp_c);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 2000; i++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
      n_vec++;
      if (tc !== exp_tc || load_err !== exp_err || j_vec !== exp_t || k_vec !== exp_t) begin
        n_err++;
        $display("FAIL rand_comb: tc=%b err=%b j=%h k=%h want %b %b %h", tc, load_err, j_vec,
                 k_vec, exp_tc, exp_err, exp_t);
      end
      tick();
      exp_c = exp_q.pop_front();
      n_vec++;
      if (count !== exp_c || count >= 4'd10) begin
        n_err++;
        $display("FAIL rand_count: got %h want %h (<10)", count, exp_c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_priority();
    test_illegal_load();
    test_hold_flip();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
